// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo_unit
// Purpose  : Multi-cycle integer multiply / divide unit that owns the
//            architectural HI/LO register pair of the MIPS datapath.
//            Supports MULT(U), DIV(U), MADD(U), MSUB(U), MTHI and MTLO.
//            Multiply is radix-2 iterative (WIDTH cycles) or single-cycle
//            when FAST_MUL=1. Divide is restoring radix-2 on magnitudes
//            (WIDTH cycles) followed by one sign-fix cycle.
// Ports    : Clk       - clock, rising edge
//            Rst       - asynchronous active-low reset
//            Start     - issue Op/A/B this cycle
//            Op[3:0]   - operation code (10..15 are no-ops)
//            A, B      - rs / rt operands
//            ReadHiLo  - an mfhi/mflo is in its reading stage
//            Flush     - abort the in-flight operation
//            HI, LO    - architectural HI / LO
//            Busy      - operation in flight
//            Done      - one-cycle pulse after a MUL/DIV commit
//            Stall     - Busy & (ReadHiLo | Start), combinational
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_hilo_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  // Accumulate mode applied to {HI,LO} when a multiply commits.
  localparam logic [1:0] M_SET = 2'd0;
  localparam logic [1:0] M_ADD = 2'd1;
  localparam logic [1:0] M_SUB = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;
  // Multiply: running product. Divide: {remainder, quotient/dividend}.
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  // Multiply: multiplier (shifted right). Divide: divisor magnitude.
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sgn_q,    sgn_d;
  logic [1:0]         mode_q,   mode_d;
  logic               a_neg_q,  a_neg_d;
  logic               b_neg_q,  b_neg_d;
  logic               b_zero_q, b_zero_d;

  // ---------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------
  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [1:0]       w_mode;

  assign w_accept = Start & ~Flush & (state_q == S_IDLE);
  assign w_is_mul = (Op == OP_MULT) | (Op == OP_MULTU) | (Op == OP_MADD) |
                    (Op == OP_MADDU) | (Op == OP_MSUB) | (Op == OP_MSUBU);
  assign w_is_div = (Op == OP_DIV) | (Op == OP_DIVU);
  // Even op codes in 0..7 are the signed variants.
  assign w_signed = ~Op[0];
  assign w_a_neg  = w_signed & A[WIDTH-1];
  assign w_b_neg  = w_signed & B[WIDTH-1];
  // -(2^(WIDTH-1)) wraps onto itself, which is the correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (-A) : A;
  assign w_b_mag  = w_b_neg ? (-B) : B;

  always_comb begin
    w_mode = M_SET;
    if ((Op == OP_MADD) || (Op == OP_MADDU)) begin
      w_mode = M_ADD;
    end else if ((Op == OP_MSUB) || (Op == OP_MSUBU)) begin
      w_mode = M_SUB;
    end
  end

  // ---------------------------------------------------------------------
  // Multiply datapath
  // ---------------------------------------------------------------------
  logic               w_cnt_last;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_mul_result;

  assign w_cnt_last = (cnt_q == CNT_LAST);

  // For a signed multiplier the top bit carries weight -2^(WIDTH-1), so
  // the final partial product is subtracted instead of added.
  always_comb begin
    w_mul_step = acc_q;
    if (mplier_q[0]) begin
      if (w_cnt_last && sgn_q) begin
        w_mul_step = acc_q - mcand_q;
      end else begin
        w_mul_step = acc_q + mcand_q;
      end
    end
  end

  if (FAST_MUL) begin : g_fast_mul
    logic [2*WIDTH-1:0] w_mplier_ext;
    assign w_mplier_ext = {{WIDTH{sgn_q & mplier_q[WIDTH-1]}}, mplier_q};
    assign w_prod       = mcand_q * w_mplier_ext;
    assign w_mul_last   = 1'b1;
  end else begin : g_iter_mul
    assign w_prod       = w_mul_step;
    assign w_mul_last   = w_cnt_last;
  end

  // The accumulate base is the {HI,LO} present at the commit edge.
  always_comb begin
    case (mode_q)
      M_ADD:   w_mul_result = {hi_q, lo_q} + w_prod;
      M_SUB:   w_mul_result = {hi_q, lo_q} - w_prod;
      default: w_mul_result = w_prod;
    endcase
  end

  // ---------------------------------------------------------------------
  // Divide datapath (restoring)
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Shift the next dividend bit into the partial remainder and try to
  // subtract the divisor; a clear borrow bit means the subtraction fits.
  assign w_trial    = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_trial - {1'b0, mplier_q};
  assign w_div_step = w_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign w_quo_mag  = acc_q[WIDTH-1:0];
  assign w_rem_mag  = acc_q[2*WIDTH-1:WIDTH];
  // Divide-by-zero naturally yields an all-ones magnitude quotient; it is
  // forced so the sign fix cannot disturb it. The remainder magnitude is
  // |A|, so restoring the dividend sign gives HI = A.
  assign w_quo_fix  = b_zero_q ? {WIDTH{1'b1}}
                    : ((a_neg_q ^ b_neg_q) ? (-w_quo_mag) : w_quo_mag);
  assign w_rem_fix  = a_neg_q ? (-w_rem_mag) : w_rem_mag;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sgn_d    = sgn_q;
    mode_d   = mode_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{w_a_neg}}, A};
            mplier_d = B;
            sgn_d    = w_signed;
            mode_d   = w_mode;
          end else if (w_is_div) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, w_a_mag};
            mplier_d = w_b_mag;
            sgn_d    = w_signed;
            a_neg_d  = w_a_neg;
            b_neg_d  = w_b_neg;
            b_zero_d = (B == '0);
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end

      S_MUL: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else if (w_mul_last) begin
          state_d = S_IDLE;
          hi_d    = w_mul_result[2*WIDTH-1:WIDTH];
          lo_d    = w_mul_result[WIDTH-1:0];
          done_d  = 1'b1;
        end else begin
          acc_d    = w_mul_step;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CW'(1);
        end
      end

      S_DIV: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = w_div_step;
          if (w_cnt_last) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin // S_FIX
        state_d = S_IDLE;
        if (!Flush) begin
          lo_d   = w_quo_fix;
          hi_d   = w_rem_fix;
          done_d = 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      mode_q   <= M_SET;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
      mode_q   <= mode_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Busy  = (state_q != S_IDLE);
  assign Done  = done_q;
  assign Stall = Busy & (ReadHiLo | Start);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_hilo_unit
// Purpose  : Self-checking bench for muldiv_hilo_unit. A 32-bit iterative
//            instance runs a table of operations whose results are checked
//            through a scoreboard on Done; hand-written sequences cover
//            stall, flush, reset and an 8-bit single-cycle-multiply instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, ReadHiLo, Flush;
  logic [3:0]  Op;
  logic [31:0] A, B, HI, LO;
  logic        Busy, Done, Stall;

  logic        Start8;
  logic [3:0]  Op8;
  logic [7:0]  A8, B8, HI8, LO8;
  logic        Busy8, Done8, Stall8;
  logic        ReadHiLo8 = 1'b0;
  logic        Flush8    = 1'b0;

  always #5 Clk = ~Clk;

  muldiv_hilo_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .ReadHiLo(ReadHiLo), .Flush(Flush), .HI(HI), .LO(LO),
    .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  muldiv_hilo_unit #(.WIDTH(8), .FAST_MUL(1'b1)) dut8 (
    .Clk(Clk), .Rst(Rst), .Start(Start8), .Op(Op8), .A(A8), .B(B8),
    .ReadHiLo(ReadHiLo8), .Flush(Flush8), .HI(HI8), .LO(LO8),
    .Busy(Busy8), .Done(Done8), .Stall(Stall8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every Done pops one expected {HI,LO}.
  always @(negedge Clk) begin
    if (Rst && Done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: Done=1 with got HI=%h LO=%h, expected no Done", HI, LO);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({HI, LO} !== {e.hi, e.lo}) begin
          n_fail++;
          $display("FAIL sb_hilo: got %h_%h, expected %h_%h", HI, LO, e.hi, e.lo);
        end
      end
      chk("done_one_cycle", {63'd0, done_prev}, 64'd0);
    end
    done_prev = Done;
  end

  // Issue one op at a negedge; for MUL/DIV wait for Done and check
  // latency, Busy duration and that HI/LO hold until the commit edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    logic [31:0] old_hi, old_lo;
    int k, busy_cnt;
    logic held;
    old_hi = HI;
    old_lo = LO;
    if (lat != 0) sb.push_back('{hi: ehi, lo: elo});
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    if (lat == 0) begin
      chk("imm_busy", {63'd0, Busy}, 64'd0);
      chk("imm_done", {63'd0, Done}, 64'd0);
      chk("imm_hilo", {HI, LO}, {ehi, elo});
      return;
    end
    k = 0;
    busy_cnt = int'(Busy);
    held = 1'b1;
    while (!Done && k < 100) begin
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
      @(posedge Clk);
      k++;
      @(negedge Clk);
      busy_cnt += int'(Busy);
    end
    chk("latency", 64'(k), 64'(lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat));
    chk("hilo_held", {63'd0, held}, 64'd1);
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ehi, input logic [7:0] elo, input int lat);
    int k;
    Op8 = op; A8 = a; B8 = b; Start8 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start8 = 1'b0;
    k = 0;
    while (!Done8 && k < 50) begin
      @(posedge Clk);
      k++;
      @(negedge Clk);
    end
    chk("w8_latency", 64'(k), 64'(lat));
    chk("w8_hilo", {48'd0, HI8, LO8}, {48'd0, ehi, elo});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[20];

  initial begin
    logic [31:0] s_hi, s_lo;
    logic stall_ok, saw_done;
    int k;

    vecs[0]  = '{4'd0,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 32};
    vecs[1]  = '{4'd1,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 32};
    vecs[2]  = '{4'd2,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{4'd3,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 33};
    vecs[4]  = '{4'd2,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5]  = '{4'd2,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[6]  = '{4'd2,  32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 33};
    vecs[7]  = '{4'd3,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
    vecs[8]  = '{4'd8,  32'd0,        32'd0,        32'h00000000, 32'h0000000E, 0};
    vecs[9]  = '{4'd9,  32'd10,       32'd0,        32'h00000000, 32'h0000000A, 0};
    vecs[10] = '{4'd4,  32'd3,        32'd4,        32'h00000000, 32'h00000016, 32};
    vecs[11] = '{4'd6,  32'd5,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFFD, 32};
    vecs[12] = '{4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFE, 32};
    vecs[13] = '{4'd7,  32'd2,        32'd3,        32'hFFFFFFFD, 32'hFFFFFFF8, 32};
    vecs[14] = '{4'd12, 32'd9,        32'd9,        32'hFFFFFFFD, 32'hFFFFFFF8, 0};
    vecs[15] = '{4'd0,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32};
    vecs[16] = '{4'd6,  32'd2,        32'hFFFFFFFF, 32'h40000000, 32'h00000002, 32};
    vecs[17] = '{4'd4,  32'hFFFFFFFF, 32'd5,        32'h3FFFFFFF, 32'hFFFFFFFD, 32};
    vecs[18] = '{4'd3,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};
    vecs[19] = '{4'd2,  32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};

    Rst = 1'b0; Start = 1'b0; ReadHiLo = 1'b0; Flush = 1'b0;
    Op = 4'd0; A = '0; B = '0;
    Start8 = 1'b0; Op8 = 4'd0; A8 = '0; B8 = '0;
    cycles(2);
    Rst = 1'b1;
    @(negedge Clk);
    chk("reset_hilo", {HI, LO}, 64'd0);
    chk("reset_busy_done", {62'd0, Busy, Done}, 64'd0);

    // Table of operations, issued back to back (each new Start lands in
    // the previous op's Done cycle).
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);
    end

    // Stall: MULT in flight, second Start + ReadHiLo held from cycle 5.
    sb.push_back('{hi: 32'd0, lo: 32'd42});
    Op = 4'd0; A = 32'd6; B = 32'd7; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    cycles(4);
    Op = 4'd9; A = 32'd99; Start = 1'b1; ReadHiLo = 1'b1;
    #1;
    chk("stall_asserted", {63'd0, Stall}, 64'd1);
    stall_ok = 1'b1;
    k = 0;
    while (!Done && k < 100) begin
      if (!Stall) stall_ok = 1'b0;
      @(posedge Clk);
      k++;
      @(negedge Clk);
    end
    chk("stall_held", {63'd0, stall_ok}, 64'd1);
    chk("stall_drops_in_done", {63'd0, Stall}, 64'd0);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; ReadHiLo = 1'b0;
    chk("held_mtlo_after_done", {HI, LO}, {32'd0, 32'd99});

    // Flush at cycle 20 of a MULT.
    Op = 4'd0; A = 32'd3; B = 32'd3; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    cycles(19);
    Flush = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Flush = 1'b0;
    chk("flush_busy", {63'd0, Busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done) saw_done = 1'b1;
    end
    chk("flush_no_done", {63'd0, saw_done}, 64'd0);
    chk("flush_hilo", {HI, LO}, {32'd0, 32'd99});

    // Flush on the commit edge of a MULT.
    Op = 4'd1; A = 32'd2; B = 32'd2; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    cycles(31);
    Flush = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Flush = 1'b0;
    chk("commit_flush_busy_done", {62'd0, Busy, Done}, 64'd0);
    chk("commit_flush_hilo", {HI, LO}, {32'd0, 32'd99});

    // Flush in IDLE blocks a same-cycle MTHI.
    Op = 4'd8; A = 32'd55; Start = 1'b1; Flush = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    chk("idle_flush_blocks", {HI, LO}, {32'd0, 32'd99});

    // Reset in the middle of a DIV, then a fresh MULTU.
    run_op(4'd8, 32'd5, 32'd0, 32'd5, 32'd99, 0);
    Op = 4'd2; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    cycles(9);
    Rst = 1'b0;
    #1;
    chk("rst_mid_hilo", {HI, LO}, 64'd0);
    chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    run_op(4'd1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 32);

    // 8-bit single-cycle-multiply instance.
    run8(4'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1);
    run8(4'd0, 8'hFF, 8'hFF, 8'h00, 8'h01, 1);
    run8(4'd3, 8'd200, 8'd7, 8'd4, 8'd28, 9);
    run8(4'd2, 8'hF9, 8'd2, 8'hFF, 8'hFD, 9);

    cycles(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle integer multiply/divide unit that owns the architectural HI/LO pair for the pipelined MIPS datapath.
- Replaces the single-cycle HI/LO path in the EX stage: iterative radix-2 multiply and divide, multiply-accumulate, and explicit HI/LO moves.
- Parametrised in operand width, with an optional single-cycle multiplier.
- Exposes busy/stall, done and flush handshakes so the hazard logic can hold dependent instructions.

Parameters:
- WIDTH, 32: operand/HI/LO width. Even, >= 4.
- FAST_MUL, 0: 1 = multiply ops finish in 1 cycle; 0 = iterative, WIDTH cycles.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  issue the operation on Op/A/B this cycle.
- Op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10-15 no-op.
- A  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  in  WIDTH  rt operand (divisor / multiplier).
- ReadHiLo  in  1  an mfhi/mflo is in the reading stage this cycle.
- Flush  in  1  abort the in-flight operation (branch/jump squash).
- HI  out  WIDTH  architectural HI.
- LO  out  WIDTH  architectural LO.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse after HI/LO commit from MUL/DIV.
- Stall  out  1  combinational: Busy & (ReadHiLo | Start).

Behaviour:
- Reset (Rst=0, asynchronous):
  - HI=0, LO=0, Busy=0, Done=0.
  - State=IDLE, counter=0, internal operands cleared.
  - Applies mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV, FIX.
- Accept rule: Start is accepted only in IDLE with Flush=0.
  - Start while Busy is ignored and Stall=1; the pipeline must hold and re-present the op.
  - No-op codes with Start are accepted but do nothing; Busy stays 0.
- MTHI/MTLO: HI (resp. LO) <= A at the accepting edge. Busy and Done stay 0. Stall never results.
- Multiply (ops 0,1,4-7):
  - Signed ops sign-extend A and B to 2*WIDTH; unsigned ops zero-extend.
  - Product P is 2*WIDTH bits.
  - MULT/MULTU: {HI,LO} <= P.
  - MADD/MADDU: {HI,LO} <= {HI,LO} + P.
  - MSUB/MSUBU: {HI,LO} <= {HI,LO} - P.
  - Arithmetic wraps mod 2^(2*WIDTH). The {HI,LO} value used for accumulate is sampled at commit.
- Divide (ops 2,3):
  - Restoring, one quotient bit per cycle on magnitudes.
  - FIX state applies signs: quotient negative iff operand signs differ (signed only); remainder takes the dividend's sign.
  - Result: LO <= quotient, HI <= remainder.
- Latency N (accept edge = edge 0, commit at edge N):
  - Multiply: N = WIDTH if FAST_MUL=0, N = 1 if FAST_MUL=1.
  - Divide: N = WIDTH + 1, i.e. WIDTH DIV cycles plus 1 FIX cycle.
  - Busy=1 after edge 0 through edge N; Busy=0 after edge N.
  - Done=1 for exactly the cycle after edge N.
  - HI/LO outputs hold their old values until edge N.
- Divide special cases, committed at the normal latency:
  - B=0: LO = all ones; HI = A.
  - Signed A = -2^(WIDTH-1), B = -1: LO = A, HI = 0.
- Flush:
  - While Busy: next edge returns to IDLE, Busy=0, no Done, HI/LO unchanged.
  - Flush on the commit edge wins: no commit.
  - In IDLE, Flush blocks a same-cycle Start, including MTHI/MTLO.
- Back-to-back: a new Start is accepted in the Done cycle, where Busy=0.
- Stall is purely combinational from the registered Busy; it has no dependency on HI/LO.

Test Plan:
- Reset mid-DIV at cycle 10 -> HI=LO=0, Busy=0 immediately; a fresh MULTU 0xFFFFFFFF*2 then gives HI=1, LO=0xFFFFFFFE at edge 32.
- WIDTH=32, FAST_MUL=0, MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB at edge 32; Busy high 32 cycles; Done one cycle.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at edge 33. DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0, MTLO 10, then MADD 3*4 -> {HI,LO}={0,22}; then MSUB 5*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- MULT accepted, Start+ReadHiLo asserted at cycle 5 -> Stall=1 and second Start ignored until Done; Flush at cycle 20 -> Busy=0 next cycle, HI/LO unchanged, no Done.
- FAST_MUL=1, WIDTH=8: MULTU 0xFF*0xFF -> HI=0xFE, LO=0x01 at edge 1; Done in cycle 2; DIVU 200/7 -> LO=28, HI=4 at edge 9.
